// File: rtl/op_fetch.sv
// op_fetch: read-side sequencer for the single-port opcode RAM.
// Walks a byte PC, issues one RAM read per cycle when credit allows, and buffers the
// returned bytes (with their addresses) in a small FIFO. The decoder drains the FIFO over
// a valid/ready handshake. A jump flushes buffered and in-flight bytes; halt stops new reads.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   halt                 suppress new RAM reads
//   jmp_valid, jmp_addr  redirect pulse and target
//   mem_ce, mem_oce      RAM read strobe / output enable (identical)
//   mem_wre              RAM write enable, tied low
//   mem_ad               RAM address (current PC)
//   mem_dout             RAM read data, valid the cycle after mem_ce
//   op_valid, op_data    FIFO head valid / byte
//   op_addr              address the head byte was read from
//   op_ready             decoder accepts the head byte
module op_fetch #(
  parameter int unsigned   AW       = 8,
  parameter int unsigned   DW       = 8,
  parameter int unsigned   DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_addr,
  output logic          mem_ce,
  output logic          mem_oce,
  output logic          mem_wre,
  output logic [AW-1:0] mem_ad,
  input  logic [DW-1:0] mem_dout,
  output logic          op_valid,
  output logic [DW-1:0] op_data,
  output logic [AW-1:0] op_addr,
  input  logic          op_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [AW-1:0] addr_mem_q [DEPTH];

  logic credit_ok;
  logic issue;
  logic push;
  logic pop;

  // Credit uses the start-of-cycle count: a same-cycle pop frees its slot only next cycle.
  assign credit_ok = (32'(count_q) + 32'(inflight_q)) < DEPTH;
  assign issue     = !reset && !halt && !jmp_valid && credit_ok;
  // A jump kills the byte returning this cycle.
  assign push      = inflight_q && !jmp_valid;
  assign pop       = op_valid && op_ready;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    req_addr_d = req_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (jmp_valid) begin
      pc_d = jmp_addr;
    end else if (issue) begin
      pc_d = pc_q + AW'(1);
    end

    if (issue) begin
      req_addr_d = pc_q;
    end

    if (jmp_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      req_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        data_mem_q[wr_ptr_q] <= mem_dout;
        addr_mem_q[wr_ptr_q] <= req_addr_q;
      end
    end
  end

  always_comb begin
    mem_ce   = issue;
    mem_oce  = issue;
    mem_wre  = 1'b0;
    mem_ad   = pc_q;
    op_valid = (count_q != '0);
    op_data  = data_mem_q[rd_ptr_q];
    op_addr  = addr_mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_op_fetch.sv
// Directed bench for op_fetch with a behavioural 256x8 RAM (registered read).
module tb_op_fetch;

  logic       clk;
  logic       reset;
  logic       halt;
  logic       jmp_valid;
  logic [7:0] jmp_addr;
  logic       mem_ce;
  logic       mem_oce;
  logic       mem_wre;
  logic [7:0] mem_ad;
  logic [7:0] mem_dout;
  logic       op_valid;
  logic [7:0] op_data;
  logic [7:0] op_addr;
  logic       op_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [256];
  logic [15:0] pops [$];
  logic [7:0]  issues [$];

  op_fetch #(
    .AW      (8),
    .DW      (8),
    .DEPTH   (2),
    .RESET_PC(8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .halt     (halt),
    .jmp_valid(jmp_valid),
    .jmp_addr (jmp_addr),
    .mem_ce   (mem_ce),
    .mem_oce  (mem_oce),
    .mem_wre  (mem_wre),
    .mem_ad   (mem_ad),
    .mem_dout (mem_dout),
    .op_valid (op_valid),
    .op_data  (op_data),
    .op_addr  (op_addr),
    .op_ready (op_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data for the address strobed this cycle appears next cycle.
  always @(posedge clk) begin
    if (mem_ce) mem_dout <= ram[mem_ad];
  end

  // Handshake and issue log, sampled mid-cycle when everything is stable.
  always @(negedge clk) begin
    if (!reset && !jmp_valid && op_valid && op_ready) pops.push_back({op_addr, op_data});
    if (mem_ce) issues.push_back(mem_ad);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pop_at(input int k);
    if (k < pops.size()) return pops[k];
    return 16'hxxxx;
  endfunction

  function automatic logic [15:0] exp_pop(input logic [7:0] a);
    return {a, ram[a]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset asserted at a drive point; caller releases it.
  task automatic do_reset();
    reset     = 1'b1;
    halt      = 1'b0;
    jmp_valid = 1'b0;
    jmp_addr  = 8'h00;
    repeat (2) cyc();
    pops.delete();
    issues.delete();
  endtask

  // Called at a sample point; stays at a sample point.
  task automatic wait_issue(input logic [7:0] a, output logic found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_ce && mem_ad == a) begin
        found = 1'b1;
        break;
      end
      cyc();
      #1;
    end
  endtask

  logic found;
  logic no5;

  initial begin
    ram[0] = 8'h46;
    ram[1] = 8'h20;
    ram[2] = 8'h42;
    ram[3] = 8'h21;
    for (int i = 4; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    mem_dout = 8'h00;
    op_ready = 1'b1;

    // 1: reset state and first fetches
    do_reset();
    #1;
    chk("rst_op_valid", op_valid, 0);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_op_data", op_data, 0);
    chk("rst_op_addr", op_addr, 0);
    chk("rst_mem_ad", mem_ad, 0);
    chk("rst_mem_wre", mem_wre, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("t1_ce_c1", mem_ce, 1);
    chk("t1_oce_c1", mem_oce, 1);
    chk("t1_ad_c1", mem_ad, 8'h00);
    cyc(); #1;
    chk("t1_ad_c2", {mem_ce, mem_ad}, {1'b1, 8'h01});
    chk("t1_valid_c2", op_valid, 0);
    cyc(); #1;
    // Byte 0 registered in the FIFO; two credits in use so no issue this cycle.
    chk("t1_head_c3", {op_valid, op_addr, op_data}, {1'b1, 8'h00, 8'h46});
    chk("t1_ce_c3", mem_ce, 0);
    repeat (10) cyc();
    chk("t1_pop0", pop_at(0), 16'h0046);
    chk("t1_pop1", pop_at(1), 16'h0120);
    chk("t1_pop2", pop_at(2), 16'h0242);
    chk("t1_pop3", pop_at(3), 16'h0321);

    // 2: backpressure fills exactly DEPTH entries
    do_reset();
    op_ready = 1'b0;
    reset    = 1'b0;
    repeat (6) cyc();
    #1;
    chk("t2_head", {op_valid, op_addr, op_data}, {1'b1, 8'h00, 8'h46});
    chk("t2_ce_stall", mem_ce, 0);
    chk("t2_issues", issues.size(), 2);
    op_ready = 1'b1;
    repeat (14) cyc();
    for (int k = 0; k < 5; k++) chk("t2_pop", pop_at(k), exp_pop(8'(k)));

    // 3: jump while the read of addr 5 is in flight
    do_reset();
    op_ready = 1'b1;
    reset    = 1'b0;
    #1;
    wait_issue(8'h05, found);
    chk("t3_found5", found, 1);
    cyc();
    jmp_valid = 1'b1;
    jmp_addr  = 8'h10;
    pops.delete();
    #1;
    chk("t3_ce_jmp", mem_ce, 0);
    cyc();
    jmp_valid = 1'b0;
    #1;
    chk("t3_flushed", op_valid, 0);
    chk("t3_issue10", {mem_ce, mem_ad}, {1'b1, 8'h10});
    cyc(); #1;
    chk("t3_empty2", op_valid, 0);
    cyc(); #1;
    chk("t3_head10", {op_valid, op_addr, op_data}, {1'b1, 8'h10, ram[8'h10]});
    repeat (8) cyc();
    chk("t3_pop0", pop_at(0), exp_pop(8'h10));
    chk("t3_pop1", pop_at(1), exp_pop(8'h11));
    no5 = 1'b1;
    foreach (pops[k]) if (pops[k][15:8] == 8'h05) no5 = 1'b0;
    chk("t3_no_addr5", no5, 1);

    // 4: jump near the top of the address space wraps
    jmp_valid = 1'b1;
    jmp_addr  = 8'hFE;
    pops.delete();
    cyc();
    jmp_valid = 1'b0;
    repeat (12) cyc();
    chk("t4_pop0", pop_at(0), exp_pop(8'hFE));
    chk("t4_pop1", pop_at(1), exp_pop(8'hFF));
    chk("t4_pop2", pop_at(2), exp_pop(8'h00));
    chk("t4_pop3", pop_at(3), exp_pop(8'h01));

    // 5: halt the cycle after an issue
    do_reset();
    op_ready = 1'b1;
    reset    = 1'b0;
    #1;
    wait_issue(8'h03, found);
    chk("t5_found3", found, 1);
    cyc();
    halt = 1'b1;
    pops.delete();
    issues.delete();
    #1;
    chk("t5_ce_halt", mem_ce, 0);
    repeat (5) cyc();
    #1;
    chk("t5_no_issue", issues.size(), 0);
    chk("t5_last_pop", (pops.size() > 0) ? pops[$] : 16'hxxxx, exp_pop(8'h03));
    chk("t5_drained", op_valid, 0);
    cyc();
    halt = 1'b0;
    #1;
    chk("t5_resume", {mem_ce, mem_ad}, {1'b1, 8'h04});

    // 6: reset with a buffered byte and a read in flight
    do_reset();
    op_ready = 1'b0;
    reset    = 1'b0;
    cyc();
    cyc();
    #1;
    chk("t6_pre_valid", op_valid, 1);
    reset = 1'b1;
    cyc(); #1;
    chk("t6_rst_valid", op_valid, 0);
    chk("t6_rst_ce", mem_ce, 0);
    chk("t6_rst_head", {op_addr, op_data}, 16'h0000);
    pops.delete();
    reset    = 1'b0;
    op_ready = 1'b1;
    #1;
    chk("t6_restart", {mem_ce, mem_ad}, {1'b1, 8'h00});
    repeat (12) cyc();
    for (int k = 0; k < 4; k++) chk("t6_pop", pop_at(k), exp_pop(8'(k)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
